// File: rtl/sr_mem_pkg.sv
// rtl/sr_mem_pkg.sv - shared types and constants for the load/store sequencer
package sr_mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/sr_load_extend.sv
// rtl/sr_load_extend.sv - lane-select and sign/zero-extend a captured load word
module sr_load_extend
  import sr_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  f3,
  output logic [31:0] wbData
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {addr_lo, 3'b000};
    case (f3)
      F3_B:    wbData = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    wbData = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   wbData = {24'h0, shifted[7:0]};
      F3_HU:   wbData = {16'h0, shifted[15:0]};
      default: wbData = word;
    endcase
  end

endmodule

// File: rtl/sr_mem_sequencer.sv
// rtl/sr_mem_sequencer.sv - multi-cycle RV32I load/store sequencer onto a req/ack bus
module sr_mem_sequencer
  import sr_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TMO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [2:0]  cmdF3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic        wbEn,
  output logic [31:0] wbData,
  output logic        memErr,
  output logic [1:0]  errCause,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck
);

  state_t           state;
  logic             is_load_q;
  logic [2:0]       f3_q;
  logic [31:0]      addr_q;
  logic [31:0]      sdata_q;
  logic [31:0]      rdata_q;
  logic [1:0]       cause_q;
  logic [TMO_W-1:0] tmo_cnt;

  logic             mem_op;
  logic             f3_legal;
  logic             misaligned;
  logic [3:0]       be_raw;
  logic [31:0]      ext_data;

  assign mem_op = isLoad | isStore;

  // Unsigned sizes exist only for loads; a simultaneous load+store decodes as a load.
  always_comb begin
    f3_legal = 1'b0;
    case (cmdF3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = isLoad;
      default:          f3_legal = 1'b0;
    endcase
    misaligned = 1'b0;
    case (cmdF3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_load_q <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= 32'h0;
      sdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      cause_q   <= ERR_NONE;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            is_load_q <= isLoad;
            f3_q      <= cmdF3;
            addr_q    <= addr;
            sdata_q   <= storeData;
            tmo_cnt   <= '0;
            if (!f3_legal) begin
              cause_q <= ERR_SIZE;
              state   <= ERR;
            end else if (misaligned) begin
              cause_q <= ERR_MISALIGN;
              state   <= ERR;
            end else begin
              cause_q <= ERR_NONE;
              state   <= REQ;
            end
          end
        end
        REQ: begin
          // An ack on the final count wins over the timeout.
          if (memAck) begin
            if (is_load_q) rdata_q <= memRdata;
            state <= DONE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            cause_q <= ERR_TIMEOUT;
            state   <= ERR;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be_raw   = 4'b0001 << addr_q[1:0];
        memWdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        be_raw   = 4'b0011 << addr_q[1:0];
        memWdata = {2{sdata_q[15:0]}};
      end
      default: begin
        be_raw   = 4'b1111;
        memWdata = sdata_q;
      end
    endcase
  end

  sr_load_extend u_load_extend (
    .word    (rdata_q),
    .addr_lo (addr_q[1:0]),
    .f3      (f3_q),
    .wbData  (ext_data)
  );

  // Decoded from the async-reset state so memReq falls the instant rst_n asserts.
  assign memReq   = (state == REQ);
  assign stall    = (state == IDLE) ? mem_op : (state == REQ);
  assign memWe    = memReq & ~is_load_q;
  assign memAddr  = {addr_q[31:2], 2'b00};
  assign memBe    = memReq ? be_raw : 4'b0000;
  assign wbEn     = (state == DONE) & is_load_q;
  assign wbData   = wbEn ? ext_data : 32'h0;
  assign memErr   = (state == ERR);
  assign errCause = memErr ? cause_q : ERR_NONE;

endmodule

// File: tb/tb_sr_mem_sequencer.sv
// tb/tb_sr_mem_sequencer.sv - directed self-checking bench for sr_mem_sequencer
module tb_sr_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        isLoad = 1'b0, isStore = 1'b0;
  logic [2:0]  cmdF3 = 3'b000;
  logic [31:0] addr = 32'h0, storeData = 32'h0, memRdata = 32'h0;
  logic        memAck = 1'b0;
  logic        stall, wbEn, memErr, memReq, memWe;
  logic [31:0] wbData, memAddr, memWdata;
  logic [1:0]  errCause;
  logic [3:0]  memBe;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sr_mem_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .isLoad(isLoad), .isStore(isStore), .cmdF3(cmdF3),
    .addr(addr), .storeData(storeData), .stall(stall), .wbEn(wbEn), .wbData(wbData),
    .memErr(memErr), .errCause(errCause), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memBe(memBe), .memWdata(memWdata), .memRdata(memRdata),
    .memAck(memAck)
  );

  int          o_stall, o_req;
  logic [3:0]  o_be;
  logic        o_we, o_wben, o_err, o_leak, o_moved, o_end;
  logic [31:0] o_addr, o_wdata, o_wbdata;
  logic [1:0]  o_cause;

  // Drives one instruction from IDLE until the release cycle; ack on REQ cycle index ack_at.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int ack_at);
    int cyc;
    o_stall = 0; o_req = 0; o_be = 4'h0; o_we = 1'b0; o_addr = 32'h0; o_wdata = 32'h0;
    o_wben = 1'b0; o_err = 1'b0; o_wbdata = 32'h0; o_cause = 2'b00;
    o_leak = 1'b0; o_moved = 1'b0; o_end = 1'b0;
    isLoad = ld; isStore = st; cmdF3 = f3; addr = a; storeData = sd;
    memAck = 1'b0; memRdata = 32'hA5A5_5A5A;
    cyc = 0;
    while (!o_end && cyc < 60) begin
      #1;
      if (!stall) begin
        o_end = 1'b1; o_wben = wbEn; o_wbdata = wbData; o_err = memErr; o_cause = errCause;
        isLoad = 1'b0; isStore = 1'b0;
      end else begin
        o_stall++;
        if (wbEn || memErr || wbData != 32'h0 || errCause != 2'b00) o_leak = 1'b1;
        if (memReq) begin
          if (o_req == 0) begin
            o_be = memBe; o_we = memWe; o_addr = memAddr; o_wdata = memWdata;
          end else if (memBe !== o_be || memWe !== o_we || memAddr !== o_addr || memWdata !== o_wdata) begin
            o_moved = 1'b1;
          end
          if (o_req == ack_at) begin memAck = 1'b1; memRdata = rd; end
          o_req++;
        end
      end
      @(posedge clk); #1;
      memAck = 1'b0; memRdata = 32'hA5A5_5A5A;
      if (cyc == 0) begin cmdF3 = 3'b111; addr = 32'hFFFF_FFFF; storeData = 32'h5555_5555; end
      cyc++;
    end
    n_checks++; if (o_end !== 1'b1) $display("FAIL access_end got %b want 1", o_end); else n_pass++;
    n_checks++; if (o_leak !== 1'b0) $display("FAIL no_strobe_leak got %b want 0", o_leak); else n_pass++;
    n_checks++; if (o_moved !== 1'b0) $display("FAIL bus_stable got %b want 0", o_moved); else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (memReq !== 1'b0) $display("FAIL rst_memreq got %b want 0", memReq); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else n_pass++;
    n_checks++; if ({wbEn, memErr, errCause, memBe} !== 8'h00) $display("FAIL rst_outs got %h want 00", {wbEn, memErr, errCause, memBe}); else n_pass++;
    n_checks++; if (wbData !== 32'h0) $display("FAIL rst_wbdata got %h want 0", wbData); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_no_mem_op();
    isLoad = 1'b0; isStore = 1'b0; memAck = 1'b1; memRdata = 32'h1234_5678;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL nomem_stall got %b want 0", stall); else n_pass++;
    @(posedge clk); #1; memAck = 1'b0;
    #1;
    n_checks++; if ({stall, wbEn, memReq, memErr} !== 4'b0000) $display("FAIL stray_ack got %b want 0000", {stall, wbEn, memReq, memErr}); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0);
    n_checks++; if (o_be !== 4'b1111) $display("FAIL lw_be got %b want 1111", o_be); else n_pass++;
    n_checks++; if (o_we !== 1'b0) $display("FAIL lw_we got %b want 0", o_we); else n_pass++;
    n_checks++; if (o_addr !== 32'h0000_1004) $display("FAIL lw_addr got %h want 00001004", o_addr); else n_pass++;
    n_checks++; if (o_stall != 2) $display("FAIL lw_stall_cycles got %0d want 2", o_stall); else n_pass++;
    n_checks++; if (o_wben !== 1'b1) $display("FAIL lw_wben got %b want 1", o_wben); else n_pass++;
    n_checks++; if (o_wbdata !== 32'hDEAD_BEEF) $display("FAIL lw_wbdata got %h want deadbeef", o_wbdata); else n_pass++;
  endtask

  task automatic test_lb_lbu();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
    n_checks++; if (o_be !== 4'b1000) $display("FAIL lb_be got %b want 1000", o_be); else n_pass++;
    n_checks++; if (o_addr !== 32'h0000_1000) $display("FAIL lb_addr got %h want 00001000", o_addr); else n_pass++;
    n_checks++; if (o_wbdata !== 32'hFFFF_FF80) $display("FAIL lb_wbdata got %h want ffffff80", o_wbdata); else n_pass++;
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
    n_checks++; if (o_wbdata !== 32'h0000_0080) $display("FAIL lbu_wbdata got %h want 00000080", o_wbdata); else n_pass++;
  endtask

  task automatic test_lh_lhu();
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_0000, 1);
    n_checks++; if (o_be !== 4'b1100) $display("FAIL lh_be got %b want 1100", o_be); else n_pass++;
    n_checks++; if (o_wbdata !== 32'hFFFF_80FF) $display("FAIL lh_wbdata got %h want ffff80ff", o_wbdata); else n_pass++;
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'h80FF_0000, 0);
    n_checks++; if (o_wbdata !== 32'h0000_80FF) $display("FAIL lhu_wbdata got %h want 000080ff", o_wbdata); else n_pass++;
  endtask

  task automatic test_sh();
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3);
    n_checks++; if (o_we !== 1'b1) $display("FAIL sh_we got %b want 1", o_we); else n_pass++;
    n_checks++; if (o_be !== 4'b1100) $display("FAIL sh_be got %b want 1100", o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got %h want abcdabcd", o_wdata); else n_pass++;
    n_checks++; if (o_req != 4) $display("FAIL sh_req_cycles got %0d want 4", o_req); else n_pass++;
    n_checks++; if (o_wben !== 1'b0 || o_wbdata !== 32'h0) $display("FAIL sh_no_wb got %b/%h want 0/0", o_wben, o_wbdata); else n_pass++;
  endtask

  task automatic test_sb();
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h1234_5678, 32'h0, 0);
    n_checks++; if (o_be !== 4'b0010) $display("FAIL sb_be got %b want 0010", o_be); else n_pass++;
    n_checks++; if (o_wdata !== 32'h7878_7878) $display("FAIL sb_wdata got %h want 78787878", o_wdata); else n_pass++;
  endtask

  task automatic test_errors();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0);
    n_checks++; if (o_req != 0) $display("FAIL misalign_req got %0d want 0", o_req); else n_pass++;
    n_checks++; if (o_err !== 1'b1 || o_cause !== 2'b01) $display("FAIL misalign_err got %b/%b want 1/01", o_err, o_cause); else n_pass++;
    n_checks++; if (o_stall != 1) $display("FAIL misalign_stall got %0d want 1", o_stall); else n_pass++;
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0);
    n_checks++; if (o_err !== 1'b1 || o_cause !== 2'b11 || o_req != 0) $display("FAIL badsize_ld got %b/%b/%0d want 1/11/0", o_err, o_cause, o_req); else n_pass++;
    run_access(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h0, 32'h0, 0);
    n_checks++; if (o_err !== 1'b1 || o_cause !== 2'b11 || o_req != 0) $display("FAIL badsize_st got %b/%b/%0d want 1/11/0", o_err, o_cause, o_req); else n_pass++;
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 99);
    n_checks++; if (o_req != 16) $display("FAIL tmo_req_cycles got %0d want 16", o_req); else n_pass++;
    n_checks++; if (o_err !== 1'b1 || o_cause !== 2'b10 || o_wben !== 1'b0) $display("FAIL tmo_err got %b/%b/%b want 1/10/0", o_err, o_cause, o_wben); else n_pass++;
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1357_9BDF, 15);
    n_checks++; if (o_req != 16) $display("FAIL lastack_req got %0d want 16", o_req); else n_pass++;
    n_checks++; if (o_err !== 1'b0 || o_wben !== 1'b1 || o_wbdata !== 32'h1357_9BDF) $display("FAIL lastack_ok got %b/%b/%h want 0/1/13579bdf", o_err, o_wben, o_wbdata); else n_pass++;
  endtask

  task automatic test_reset_mid();
    isStore = 1'b1; cmdF3 = 3'b010; addr = 32'h0000_4000; storeData = 32'h1111_2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1; rst_n = 1'b0;
    #1;
    n_checks++; if (memReq !== 1'b0) $display("FAIL async_rst_memreq got %b want 0", memReq); else n_pass++;
    isStore = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL async_rst_idle got %b want 0", stall); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0, 1);
    n_checks++; if (o_be !== 4'b1111 || o_we !== 1'b1) $display("FAIL sw_be_we got %b/%b want 1111/1", o_be, o_we); else n_pass++;
    n_checks++; if (o_wdata !== 32'hCAFE_F00D || o_addr !== 32'h0000_4000) $display("FAIL sw_bus got %h/%h want cafef00d/00004000", o_wdata, o_addr); else n_pass++;
    n_checks++; if (o_req != 2 || o_err !== 1'b0 || o_wben !== 1'b0) $display("FAIL sw_done got %0d/%b/%b want 2/0/0", o_req, o_err, o_wben); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_no_mem_op();
    test_lw();
    test_lb_lbu();
    test_lh_lhu();
    test_sh();
    test_sb();
    test_errors();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
